// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per RUN cycle, LSB first, result registered in DONE.
// Optional signed-overflow output ovf_o is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf_o,
`endif
  output logic [1:0]       state_o
);

  // Handshake: start_i is a request that is accepted only on an edge where the FSM is IDLE;
  // done_o is a single-cycle valid strobe for diff_o/borrow_o, which then hold until the next run.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             bit_d;
  logic             bw_nx;
  logic             last_bit;

  assign bit_d    = a_q[0] ^ b_q[0] ^ bw_q;
  assign bw_nx    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bw_d     = bw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          cnt_d   = '0;
          bw_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Partial bits enter at the top; after WIDTH-1 steps bit 0 sits at position 0.
        res_d = (WIDTH-1)'({bit_d, res_q} >> 1);
        bw_d  = bw_nx;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          // a_q[0]/b_q[0] now hold the operand MSBs and bit_d is the result MSB.
          diff_d   = {bit_d, res_q};
          borrow_d = bw_nx;
          ovf_d    = (a_q[0] != b_q[0]) && (bit_d != a_q[0]);
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o   = (state_q == RUN);
  assign done_o   = (state_q == DONE);
  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;
  assign state_o  = state_q;

`ifdef SERIAL_SUB_OVF_EN
  assign ovf_o = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases, random ops, reset abort, back-to-back.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] a_i, b_i;
  logic         busy_o, done_o, borrow_o;
  logic [W-1:0] diff_o;
  logic [1:0]   state_o;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf_o;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .diff_o   (diff_o),
    .borrow_o (borrow_o),
`ifdef SERIAL_SUB_OVF_EN
    .ovf_o    (ovf_o),
`endif
    .state_o  (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] e;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packed as {diff, borrow, ovf}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    logic         bw, ov;
    d  = a - b;
    bw = (a < b);
    ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {d, bw, ov};
  endfunction

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_q.push_back(model(a, b));
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && (busy_o || done_o)) check_val("busy_done_excl", {31'd0, busy_o & done_o}, 32'd0);
    if (!rst_i && done_o) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("diff", {24'd0, diff_o}, {24'd0, e[W+1:2]});
        check_val("borrow", {31'd0, borrow_o}, {31'd0, e[1]});
`ifdef SERIAL_SUB_OVF_EN
        check_val("ovf", {31'd0, ovf_o}, {31'd0, e[0]});
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n);
    @(negedge clk_i);
    start_i = 1'b1; a_i = a; b_i = b;
    push_exp(a, b);
    @(negedge clk_i);
    start_i = 1'b0;
    a_i = W'($urandom_range(0, 255));
    b_i = W'($urandom_range(0, 255));
    lat = 1; busy_n = 0;
    while (!done_o && lat < 40) begin
      busy_n += int'(busy_o);
      @(negedge clk_i);
      lat++;
    end
    if (!done_o) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  int   lat, busy_n, cnt0, n;
  time  t_prev;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0;
    wait_idle_cycles(3);
    rst_i = 1'b0;
    check_val("rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("rst_done", {31'd0, done_o}, 32'd0);
    check_val("rst_diff", {24'd0, diff_o}, 32'd0);
    check_val("rst_borrow", {31'd0, borrow_o}, 32'd0);
    check_val("rst_state", {30'd0, state_o}, 32'd0);

    // Test 1: latency and busy window
    run_op(8'h05, 8'h03, lat, busy_n);
    check_val("t1_latency", lat, W + 1);
    check_val("t1_busy_cycles", busy_n, W);
    @(negedge clk_i);
    check_val("t1_hold_diff", {24'd0, diff_o}, 32'h02);
    check_val("t1_idle_state", {30'd0, state_o}, 32'd0);

    // Test 2 with hold-during-RUN check
    @(negedge clk_i);
    start_i = 1'b1; a_i = 8'h03; b_i = 8'h05; push_exp(8'h03, 8'h05);
    @(negedge clk_i); start_i = 1'b0;
    @(negedge clk_i);
    check_val("t2_run_hold_diff", {24'd0, diff_o}, 32'h02);
    check_val("t2_run_busy", {31'd0, busy_o}, 32'd1);
    n = 0;
    while (!done_o && n < 40) begin @(negedge clk_i); n++; end
    if (!done_o) check_val("t2_timeout", 32'd0, 32'd1);
    @(negedge clk_i);

    // Test 3 boundaries
    run_op(8'h80, 8'h01, lat, busy_n);
    run_op(8'h00, 8'h00, lat, busy_n);
    run_op(8'hFF, 8'h00, lat, busy_n);
    run_op(8'h00, 8'hFF, lat, busy_n);
    run_op(8'h7F, 8'h80, lat, busy_n);

    // Random operations
    for (int i = 0; i < 8; i++)
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), lat, busy_n);
    @(negedge clk_i);

    // Test 4: start during RUN is ignored
    cnt0 = done_cnt;
    @(negedge clk_i);
    start_i = 1'b1; a_i = 8'h10; b_i = 8'h01; push_exp(8'h10, 8'h01);
    @(negedge clk_i); start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1; a_i = 8'hFF; b_i = 8'hFF;
    n = 0;
    while (!done_o && n < 40) begin @(negedge clk_i); n++; end
    if (!done_o) check_val("t4_timeout", 32'd0, 32'd1);
    start_i = 1'b0;
    wait_idle_cycles(15);
    check_val("t4_done_pulses", done_cnt - cnt0, 32'd1);

    // Test 5: reset in RUN aborts
    cnt0 = done_cnt;
    @(negedge clk_i);
    start_i = 1'b1; a_i = 8'h55; b_i = 8'h11;
    @(negedge clk_i); start_i = 1'b0;
    wait_idle_cycles(3);
    rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    check_val("t5_state", {30'd0, state_o}, 32'd0);
    check_val("t5_busy", {31'd0, busy_o}, 32'd0);
    check_val("t5_done", {31'd0, done_o}, 32'd0);
    check_val("t5_diff", {24'd0, diff_o}, 32'd0);
    check_val("t5_borrow", {31'd0, borrow_o}, 32'd0);
    wait_idle_cycles(12);
    check_val("t5_no_done", done_cnt - cnt0, 32'd0);
    run_op(8'h20, 8'h10, lat, busy_n);
    @(negedge clk_i);

    // Test 6: back-to-back with start held
    @(negedge clk_i);
    start_i = 1'b1; a_i = 8'h3C; b_i = 8'h5A; push_exp(8'h3C, 8'h5A);
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!done_o && n < 40) begin @(negedge clk_i); n++; end
      if (!done_o) check_val("t6_timeout", 32'd0, 32'd1);
      if (i > 0) check_val("t6_spacing", 32'(($time - t_prev) / 10), W + 2);
      t_prev = $time;
      if (i < 2) begin
        a_i = W'($urandom_range(0, 255));
        b_i = W'($urandom_range(0, 255));
        push_exp(a_i, b_i);
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
    end

    wait_idle_cycles(15);
    check_val("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
